// File: rtl/display_pkg.sv
// Shared constants and types for the 7-segment display scan controller.
package display_pkg;

  localparam int MAX_DIGITS = 8;
  localparam int DIGIT_W    = 4;

  // Common-anode lines are active low, so "all off" is all ones.
  localparam logic [MAX_DIGITS-1:0] ANODE_OFF = '1;

  typedef logic [$clog2(MAX_DIGITS)-1:0] idx_t;

endpackage

// File: rtl/display_scan_tick.sv
// Per-slot cycle counter: counts 0..DIV-1 and flags the first and last
// cycle of every digit slot.
module scan_tick
  import display_pkg::*;
#(
  parameter int DIV   = 100000,
  parameter int CNT_W = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] cnt,
  output logic             slot_start,
  output logic             slot_end
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  assign slot_start = (cnt == '0);
  assign slot_end   = (cnt == CNT_LAST);

  // Free-running slot counter, wraps at the end of every slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (slot_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/display_scan.sv
// Time-multiplexed scan controller for an 8-digit common-anode display.
// One digit slot per DIV cycles, a blank interval at the start of each slot
// against ghosting, and a frame-based blink for time-set modes.
module display_scan
  import display_pkg::*;
#(
  parameter int N_DIGITS     = 8,
  parameter int DIV          = 100000,
  parameter int BLANK        = 1000,
  parameter int BLINK_FRAMES = 125
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [DIGIT_W*N_DIGITS-1:0] digits,
  input  logic [N_DIGITS-1:0]         hex_mask,
  input  logic [N_DIGITS-1:0]         digit_mask,
  input  logic [N_DIGITS-1:0]         blink_mask,
  output logic [DIGIT_W-1:0]          digit_code,
  output logic                        digit_sel,
  output logic                        digit_en,
  output logic [N_DIGITS-1:0]         an
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam idx_t              IDX_LAST = idx_t'(N_DIGITS - 1);
  localparam logic [FRM_W-1:0]  FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

  logic [CNT_W-1:0]   cnt;
  logic               slot_start;
  logic               slot_end;
  idx_t               idx;
  logic [FRM_W-1:0]   frame;
  logic               blink_phase;

  logic [DIGIT_W-1:0] snap_code_p0;
  logic               snap_sel_p0;
  logic               snap_show_p0;
  logic               snap_blink_p0;

  logic [DIGIT_W-1:0] live_code;
  logic               live_sel;
  logic               live_show;
  logic               live_blink;

  logic [DIGIT_W-1:0] cur_code;
  logic               cur_sel;
  logic               cur_show;
  logic               cur_blink;
  logic               past_blank;
  logic               visible;
  logic [N_DIGITS-1:0] an_next;

  scan_tick #(
    .DIV   (DIV),
    .CNT_W (CNT_W)
  ) u_tick (
    .clk        (clk),
    .rst        (rst),
    .cnt        (cnt),
    .slot_start (slot_start),
    .slot_end   (slot_end)
  );

  // Digit index, frame counter and blink phase advance at each slot end.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx         <= '0;
      frame       <= '0;
      blink_phase <= 1'b1;
    end else if (slot_end) begin
      if (idx == IDX_LAST) begin
        idx <= '0;
        if (frame == FRM_LAST) begin
          frame       <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame <= frame + 1'b1;
        end
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

  // Pick the live inputs belonging to the current digit slot.
  always_comb begin
    live_code  = '0;
    live_sel   = 1'b0;
    live_show  = 1'b0;
    live_blink = 1'b0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (idx == idx_t'(k)) begin
        live_code  = digits[DIGIT_W*k +: DIGIT_W];
        live_sel   = hex_mask[k];
        live_show  = digit_mask[k];
        live_blink = blink_mask[k];
      end
    end
  end

  // Snapshot the slot's digit at cnt==0 so mid-slot input changes are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      snap_code_p0  <= '0;
      snap_sel_p0   <= 1'b0;
      snap_show_p0  <= 1'b0;
      snap_blink_p0 <= 1'b0;
    end else if (slot_start) begin
      snap_code_p0  <= live_code;
      snap_sel_p0   <= live_sel;
      snap_show_p0  <= live_show;
      snap_blink_p0 <= live_blink;
    end
  end

  // In the snapshot cycle itself the register is not yet loaded, so the
  // output stage reads the live values directly (needed when BLANK==0).
  assign cur_code  = slot_start ? live_code  : snap_code_p0;
  assign cur_sel   = slot_start ? live_sel   : snap_sel_p0;
  assign cur_show  = slot_start ? live_show  : snap_show_p0;
  assign cur_blink = slot_start ? live_blink : snap_blink_p0;

  generate
    if (BLANK == 0) begin : g_no_blank
      assign past_blank = 1'b1;
    end else begin : g_blank
      assign past_blank = (cnt >= CNT_W'(BLANK));
    end
  endgenerate

  assign visible = past_blank && en && cur_show && !(cur_blink && !blink_phase);

  // One-hot-low anode pattern for the active slot, all off when dark.
  always_comb begin
    an_next = '1;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (visible && (idx == idx_t'(k))) begin
        an_next[k] = 1'b0;
      end
    end
  end

  // ---- output register stage ----
  // Registered outputs: one cycle behind counter, index and snapshot.
  always_ff @(posedge clk) begin
    if (rst) begin
      an         <= ANODE_OFF[N_DIGITS-1:0];
      digit_en   <= 1'b0;
      digit_code <= '0;
      digit_sel  <= 1'b0;
    end else begin
      an         <= an_next;
      digit_en   <= visible;
      digit_code <= cur_code;
      digit_sel  <= cur_sel;
    end
  end

endmodule

// File: doc/display_scan.md
# display_scan

Time-multiplexed scan controller for the multi-mode clock's 8-digit common-anode 7-segment display. Each cycle it selects one digit slot and presents that digit's 4-bit code, hex/decimal select and enable to the downstream combinational 7-segment digit decoder. It also drives the active-low anode lines. Adds a per-slot anti-ghosting blank interval and a per-digit blink function used by the clock's time-set modes.

## Interface
- `N_DIGITS`, 8: number of digit slots, 1..8.
- `DIV`, 100000: clock cycles per digit slot; minimum 2.
- `BLANK`, 1000: blanked cycles at the start of each slot; range 0..DIV-1.
- `BLINK_FRAMES`, 125: full scan frames per blink half-period; minimum 1.
- `clk`, in, 1: single clock.
- `rst`, in, 1: synchronous, active-high reset.
- `en`, in, 1: global display enable.
- `digits`, in, 4*N_DIGITS: digit k occupies bits [4k+3:4k].
- `hex_mask`, in, N_DIGITS: 1 = digit k is displayed in hex.
- `digit_mask`, in, N_DIGITS: 1 = digit k is shown.
- `blink_mask`, in, N_DIGITS: 1 = digit k blinks.
- `digit_code`, out, 4: code of the active digit, to the decoder `in`.
- `digit_sel`, out, 1: to the decoder hex select.
- `digit_en`, out, 1: to the decoder enable.
- `an`, out, N_DIGITS: anode enables, active low.

## Operation
- Slot counter `cnt` runs 0..DIV-1. At `cnt==DIV-1`, `cnt` returns to 0 and the digit index `idx` advances 0..N_DIGITS-1 with wrap.
- A frame is one full pass of `idx`. A frame counter increments when `idx` wraps to 0. When the frame counter reaches BLINK_FRAMES-1 at a wrap, it clears and `blink_phase` toggles.
- Snapshot: at `cnt==0`, `digits[idx]`, `hex_mask[idx]`, `digit_mask[idx]` and `blink_mask[idx]` are latched. Outputs for the slot come only from this snapshot, so input changes mid-slot have no effect until the next slot of that digit.
- A slot is visible when all of the following hold: `cnt>=BLANK`, `en`=1, snapshot digit_mask=1, and not (snapshot blink=1 and `blink_phase`=0).
- Visible slot: `an[idx]`=0, all other anodes 1; `digit_en`=1; `digit_code` and `digit_sel` come from the snapshot.
- Not visible: `an` is all ones and `digit_en`=0. `digit_code` and `digit_sel` still show the snapshot.
- Counters always run, including when `en`=0 or a digit is masked. Brightness therefore stays constant regardless of how many digits are lit.
- Blink phases: `blink_phase`=1 is the visible half, 0 is the off half.

## Timing
- All outputs are registered. Outputs in cycle t reflect `cnt`, `idx`, `blink_phase` and the snapshot as they were in cycle t-1 (1-cycle latency).
- Digit k is lit from cycle slot_start+BLANK+1 through slot_start+DIV, inclusive. slot_start is the cycle in which `cnt==0` for `idx==k`.
- The snapshot is taken in the same cycle `cnt==0` is observed. It is used by the output register from the next cycle onward.
- An `en` change takes effect on `an` and `digit_en` exactly 1 cycle later.
- If the frame wrap and the blink terminal count occur in the same cycle, the toggle happens in that cycle. The new phase applies from slot 0 of the new frame.
- With BLANK=0 there is no blank interval. Adjacent slots hand over with no all-off cycle.
- Reset values: `cnt`=0, `idx`=0, frame counter 0, `blink_phase`=1, snapshot 0, `an` all ones, `digit_en`=0, `digit_code`=0, `digit_sel`=0.
- Reset asserted mid-slot: all of the above take effect on the next edge. After release, scanning restarts at slot 0, `cnt`=0.

## Structure
- Package `display_pkg`:
  - `MAX_DIGITS`=8
  - `ANODE_OFF`, all ones
  - `DIGIT_W`=4
  - `idx_t` typedef, index width `$clog2(MAX_DIGITS)`
- Sub-module `scan_tick`:
  - Parameterised by DIV.
  - Outputs `cnt`, a `slot_end` pulse at `cnt==DIV-1` and a `slot_start` pulse at `cnt==0`.
  - Sync active-high reset.
- Index, frame, blink and snapshot/output logic live in `display_scan`.
- The decoder is not instantiated here. The top level connects it.

## Test plan
All scenarios use N_DIGITS=4, DIV=8, BLANK=2, BLINK_FRAMES=2.

1. Reset, then run with `en`=1, all masks visible, `digits`=16'h4321:
   - Each slot shows `an`=1111 for 2 cycles, then `an` low for 6 cycles: 1110 with code 1, then 1101 with code 2, then 1011 with code 3, then 0111 with code 4.
   - Then wraps to 1110.
2. `digits[0]`=4'hA, `hex_mask[0]`=0, then 1: `digit_code`=A in slot 0 with `digit_sel` 0, then 1.
3. Change `digits` in the middle of slot 2: `digit_code` holds the old value until slot 2 of the next frame.
4. `blink_mask`=0001 for 8 frames:
   - Slot 0 is lit in frames 0-1.
   - Slot 0 is dark (`an`=1111, `digit_en`=0) in frames 2-3.
   - The pattern repeats; other slots are unaffected.
5. Deassert `en` for 3 cycles mid-slot 1:
   - `an`=1111 and `digit_en`=0 on exactly the 3 cycles delayed by 1.
   - `idx` and `cnt` timing are unchanged.
6. Assert `rst` at `cnt`=5 of slot 3:
   - Next cycle all outputs are at reset values.
   - After release, slot 0 goes active after the 2-cycle blank.
   - `blink_phase`=1.
